// File: rtl/mio_bus.sv
// mio_bus -- memory/IO bus controller sitting directly behind the
// single-cycle CPU core.
//
// Each CPU access is decoded to either the external block-RAM port or the
// on-chip IO registers (LEDs, synchronised switches, free-running counter
// with compare/interrupt, status).
//
// Handshake: the CPU presents cpu_req with cpu_addr/cpu_we/cpu_wdata and
// holds them stable while MIO_ready is 0. An access completes in the cycle
// where MIO_ready is 1. RAM reads take RAM_LAT cycles with MIO_ready low,
// then one DONE cycle with MIO_ready high. Every other access completes in
// the cycle it is presented. With no request MIO_ready is 1.
//
// ram_rdata is sampled at the clock edge RAM_LAT edges after the edge that
// closes the ram_en cycle's predecessor; in other words the RAM must hold
// its read data valid through the last MIO_ready-low cycle.
//
// Address map (word aligned, addr[1:0] ignored):
//   0x0 .. 4*2^RAM_AW-1 : RAM
//   0xF000_0000 : switches (read) / LEDs (write)
//   0xF000_0004 : counter value (R/W)
//   0xF000_0008 : compare value (R/W)
//   0xF000_000C : status, bit0 match, bit1 error, write-1-to-clear
//   anything else : unmapped, reads 0, writes dropped
//
// Optional macro MIO_BUS_ERR_EN: when defined, unmapped requests set the
// sticky status bit1 which also drives bus_err; otherwise bit1 reads 0 and
// bus_err is tied low.
//
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-low reset
//   cpu_addr/wdata  : CPU byte address and store data
//   cpu_we, cpu_req : 1=write / 0=read, access valid
//   cpu_rdata       : read data to CPU
//   MIO_ready       : access completes this cycle
//   ram_en, ram_we  : RAM port enable / write strobe
//   ram_addr        : RAM word address (cpu_addr[RAM_AW+1:2])
//   ram_wdata       : RAM write data
//   ram_rdata       : RAM read data
//   sw_in           : asynchronous switches
//   led_out         : LED register
//   cnt_irq         : counter-match interrupt (level, = status bit0)
//   bus_err         : sticky unmapped-access flag
//   state_dbg       : FSM state, 0=IDLE 1=WAIT 2=DONE
module mio_bus #(
  parameter int RAM_LAT = 1,
  parameter int RAM_AW  = 10,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_req,
  output logic [31:0]       cpu_rdata,
  output logic              MIO_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out,
  output logic              cnt_irq,
  output logic              bus_err,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] WAIT_INIT = 3'(RAM_LAT - 1);

  state_t           state, state_n;
  logic [2:0]       wcnt;
  logic [31:0]      rdata_q;
  logic [15:0]      sw_meta, sw_sync;
  logic [CNT_W-1:0] cnt_q, cmp_q, cnt_next, cmp_next;
  logic             st_match, st_err;

  // Decode
  logic        ram_hit, io_sw, io_cnt, io_cmp, io_st, unmapped;
  logic [29:0] word;
  logic [31:0] io_rdata, cnt_ext, cmp_ext;

  // FSM-produced controls
  logic wcnt_load, wcnt_dec, capture, io_acc, io_wr, st_clr_wr;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^cpu_addr[1:0];

  assign word     = cpu_addr[31:2];
  assign ram_hit  = (cpu_addr[31:RAM_AW+2] == '0);
  assign io_sw    = (word == 30'h3C00_0000);
  assign io_cnt   = (word == 30'h3C00_0001);
  assign io_cmp   = (word == 30'h3C00_0002);
  assign io_st    = (word == 30'h3C00_0003);
  assign unmapped = ~ram_hit & ~io_sw & ~io_cnt & ~io_cmp & ~io_st;

  assign ram_addr  = cpu_addr[RAM_AW+1:2];
  assign ram_wdata = cpu_wdata;
  assign state_dbg = state;

  // IO read mux; counter/compare are zero-extended to 32 bits.
  always_comb begin
    cnt_ext = '0;
    cmp_ext = '0;
    cnt_ext[CNT_W-1:0] = cnt_q;
    cmp_ext[CNT_W-1:0] = cmp_q;
    io_rdata = '0;
    if (io_sw)       io_rdata = {16'h0000, sw_sync};
    else if (io_cnt) io_rdata = cnt_ext;
    else if (io_cmp) io_rdata = cmp_ext;
    else if (io_st)  io_rdata = {30'h0, st_err, st_match};
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Next state and outputs
  always_comb begin
    state_n   = state;
    MIO_ready = 1'b1;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    cpu_rdata = '0;
    wcnt_load = 1'b0;
    wcnt_dec  = 1'b0;
    capture   = 1'b0;
    io_acc    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cpu_req) begin
          if (ram_hit) begin
            ram_en = 1'b1;
            if (cpu_we) begin
              ram_we = 1'b1;
            end else begin
              MIO_ready = 1'b0;
              // A single wait cycle needs no counting: capture now.
              if (RAM_LAT == 1) begin
                capture = 1'b1;
                state_n = S_DONE;
              end else begin
                wcnt_load = 1'b1;
                state_n   = S_WAIT;
              end
            end
          end else begin
            io_acc    = 1'b1;
            cpu_rdata = io_rdata;
          end
        end
      end
      S_WAIT: begin
        MIO_ready = 1'b0;
        wcnt_dec  = 1'b1;
        // The counter reaches 0 at this edge: last low cycle.
        if (wcnt == 3'd1) begin
          capture = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        cpu_rdata = rdata_q;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign io_wr     = io_acc & cpu_we;
  assign st_clr_wr = io_wr & io_st;

  // Wait counter and read-data capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt    <= '0;
      rdata_q <= '0;
    end else begin
      if (wcnt_load)     wcnt <= WAIT_INIT;
      else if (wcnt_dec) wcnt <= wcnt - 3'd1;
      if (capture) rdata_q <= ram_rdata;
    end
  end

  // Switch synchroniser and LED register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
      led_out <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
      if (io_wr & io_sw) led_out <= cpu_wdata[15:0];
    end
  end

  // Counter/compare next values; a counter load wins over the increment and
  // the match is evaluated on the post-update values.
  assign cnt_next = (io_wr & io_cnt) ? cpu_wdata[CNT_W-1:0] : cnt_q + CNT_W'(1);
  assign cmp_next = (io_wr & io_cmp) ? cpu_wdata[CNT_W-1:0] : cmp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      cmp_q    <= '1;
      st_match <= 1'b0;
    end else begin
      cnt_q    <= cnt_next;
      cmp_q    <= cmp_next;
      // Set wins over a same-cycle write-1 clear.
      st_match <= (cnt_next == cmp_next) | (st_match & ~(st_clr_wr & cpu_wdata[0]));
    end
  end

  assign cnt_irq = st_match;

`ifdef MIO_BUS_ERR_EN
  logic err_set;
  assign err_set = io_acc & unmapped;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_err <= 1'b0;
    else      st_err <= err_set | (st_err & ~(st_clr_wr & cpu_wdata[1]));
  end

  assign bus_err = st_err;
`else
  logic unused_unmapped;
  assign unused_unmapped = unmapped;
  assign st_err  = 1'b0;
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mio_bus.sv
module tb_mio_bus;
  localparam int RAM_LAT = 2;
  localparam int RAM_AW  = 10;
  localparam int CNT_W   = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;
  logic              cpu_we, cpu_req, MIO_ready, ram_en, ram_we, cnt_irq, bus_err;
  logic [RAM_AW-1:0] ram_addr;
  logic [15:0]       sw_in, led_out;
  logic [1:0]        state_dbg;

  mio_bus #(.RAM_LAT(RAM_LAT), .RAM_AW(RAM_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_req(cpu_req),
    .cpu_rdata(cpu_rdata), .MIO_ready(MIO_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .sw_in(sw_in), .led_out(led_out), .cnt_irq(cnt_irq), .bus_err(bus_err),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [31:0] exp_q[$];

  logic [15:0] m_led;
  logic [31:0] cnt_base;
  int          base_cyc;
  logic [31:0] m_cmp;
  bit          m_match, m_err;
  logic [15:0] sw_hist[$];

  bit          p_led, p_cnt, p_cmp, p_st, p_err;
  logic [31:0] p_data;

  // Counter value = last loaded value plus edges elapsed since the load.
  function automatic logic [31:0] m_cnt();
    return cnt_base + 32'(cyc - base_cyc);
  endfunction

  // Two-stage synchroniser: reads see the switch value from two edges back.
  function automatic logic [31:0] m_sw();
    if (sw_hist.size() < 2) return 32'h0;
    return {16'h0, sw_hist[sw_hist.size()-2]};
  endfunction

  // 0 ram, 1 sw/led, 2 counter, 3 compare, 4 status, 5 unmapped
  function automatic int classify(input logic [31:0] a);
    if (a < 32'(4 * (1 << RAM_AW))) return 0;
    case ({a[31:2], 2'b00})
      32'hF000_0000: return 1;
      32'hF000_0004: return 2;
      32'hF000_0008: return 3;
      32'hF000_000C: return 4;
      default:       return 5;
    endcase
  endfunction

  task automatic model_reset();
    m_led = '0; cnt_base = '0; base_cyc = cyc; m_cmp = '1;
    m_match = 0; m_err = 0; sw_hist.delete();
    p_led = 0; p_cnt = 0; p_cmp = 0; p_st = 0; p_err = 0; p_data = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_common();
    chk("led_out", {16'h0, led_out}, {16'h0, m_led});
    chk("cnt_irq", {31'h0, cnt_irq}, {31'h0, m_match});
    chk("bus_err", {31'h0, bus_err}, {31'h0, m_err});
  endtask

  // One clock edge; the model applies this cycle's writes after it.
  task automatic tick();
    sw_hist.push_back(sw_in);
    @(posedge clk);
    cyc++;
    if (p_led) m_led = p_data[15:0];
    if (p_cnt) begin cnt_base = p_data; base_cyc = cyc; end
    if (p_cmp) m_cmp = p_data;
    if (m_cnt() == m_cmp) m_match = 1;
    else if (p_st && p_data[0]) m_match = 0;
`ifdef MIO_BUS_ERR_EN
    if (p_err) m_err = 1;
    else if (p_st && p_data[1]) m_err = 0;
`endif
    p_led = 0; p_cnt = 0; p_cmp = 0; p_st = 0; p_err = 0;
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_cyc();
    cpu_req = 1'b0;
    #1;
    chk("idle_ready", {31'h0, MIO_ready}, 32'h1);
    chk("idle_rdata", cpu_rdata, 32'h0);
    chk("idle_ram_en", {31'h0, ram_en}, 32'h0);
    chk("idle_state", {30'h0, state_dbg}, 32'h0);
    chk_common();
    tick();
  endtask

  task automatic io_write(input logic [31:0] a, input logic [31:0] d);
    int k;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    #1;
    chk("io_wr_ready", {31'h0, MIO_ready}, 32'h1);
    chk("io_wr_ram_en", {31'h0, ram_en}, 32'h0);
    chk_common();
    k = classify(a);
    p_data = d;
    case (k)
      1: p_led = 1;
      2: p_cnt = 1;
      3: p_cmp = 1;
      4: p_st  = 1;
      default: p_err = 1;
    endcase
    tick();
  endtask

  task automatic io_read(input logic [31:0] a);
    logic [31:0] expv;
    int k;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    #1;
    k = classify(a);
    case (k)
      1: expv = m_sw();
      2: expv = m_cnt();
      3: expv = m_cmp;
      4: expv = {30'h0, m_err, m_match};
      default: begin expv = 32'h0; p_err = 1; end
    endcase
    exp_q.push_back(expv);
    chk("io_rd_data", cpu_rdata, exp_q.pop_front());
    chk("io_rd_ready", {31'h0, MIO_ready}, 32'h1);
    chk("io_rd_ram_en", {31'h0, ram_en}, 32'h0);
    chk_common();
    tick();
  endtask

  task automatic ram_write(input logic [31:0] a, input logic [31:0] d);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    #1;
    chk("ram_wr_en", {31'h0, ram_en}, 32'h1);
    chk("ram_wr_we", {31'h0, ram_we}, 32'h1);
    chk("ram_wr_addr", {22'h0, ram_addr}, (a >> 2) & 32'(2**RAM_AW - 1));
    chk("ram_wr_data", ram_wdata, d);
    chk("ram_wr_ready", {31'h0, MIO_ready}, 32'h1);
    chk("ram_wr_state", {30'h0, state_dbg}, 32'h0);
    tick();
  endtask

  task automatic ram_read(input logic [31:0] a, input logic [31:0] d);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    ram_rdata = d;
    exp_q.push_back(d);
    #1;
    chk("ram_rd_en", {31'h0, ram_en}, 32'h1);
    chk("ram_rd_we", {31'h0, ram_we}, 32'h0);
    chk("ram_rd_addr", {22'h0, ram_addr}, (a >> 2) & 32'(2**RAM_AW - 1));
    chk("ram_rd_ready0", {31'h0, MIO_ready}, 32'h0);
    chk_common();
    tick();
    for (int i = 1; i < RAM_LAT; i++) begin
      #1;
      chk("ram_wait_ready", {31'h0, MIO_ready}, 32'h0);
      chk("ram_wait_en", {31'h0, ram_en}, 32'h0);
      chk("ram_wait_state", {30'h0, state_dbg}, 32'h1);
      tick();
    end
    #1;
    chk("ram_done_ready", {31'h0, MIO_ready}, 32'h1);
    chk("ram_done_state", {30'h0, state_dbg}, 32'h2);
    chk("ram_done_en", {31'h0, ram_en}, 32'h0);
    chk("ram_done_data", cpu_rdata, exp_q.pop_front());
    chk_common();
    tick();
    ram_rdata = $urandom;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int op;
    logic [31:0] a;
    cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_req = 1'b0;
    ram_rdata = $urandom; sw_in = '0;
    model_reset();

    // Power-on reset
    #2 rst = 1'b0;
    #1;
    chk("rst_ready", {31'h0, MIO_ready}, 32'h1);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_led", {16'h0, led_out}, 32'h0);
    chk("rst_irq", {31'h0, cnt_irq}, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
    chk("rst_state", {30'h0, state_dbg}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // RAM read at 0x10, RAM write at 0x8
    ram_read(32'h0000_0010, 32'hDEAD_BEEF);
    idle_cyc();
    ram_write(32'h0000_0008, 32'h0000_1234);

    // LED write, switches through the synchroniser
    io_write(32'hF000_0000, 32'h0000_00A5);
    chk("led_a5", {16'h0, led_out}, 32'h0000_00A5);
    sw_in = 16'h5A5A;
    idle_cyc();
    idle_cyc();
    io_read(32'hF000_0000);

    // Compare/counter match and write-1 clear
    io_write(32'hF000_0008, 32'h0000_0010);
    io_write(32'hF000_0004, 32'h0000_000E);
    idle_cyc();
    idle_cyc();
    chk("irq_rise", {31'h0, cnt_irq}, 32'h1);
    io_read(32'hF000_000C);
    io_write(32'hF000_000C, 32'h0000_0001);
    chk("irq_clear", {31'h0, cnt_irq}, 32'h0);

    // Unmapped read
    io_read(32'h8000_0000);
    chk("bus_err_after_unmapped", {31'h0, bus_err}, {31'h0, m_err});
    io_write(32'hF000_000C, 32'h0000_0002);
    idle_cyc();

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) sw_in = 16'($urandom);
      op = $urandom_range(0, 9);
      case (op)
        0: ram_read(32'($urandom_range(0, 4 * (1 << RAM_AW) - 1)), $urandom);
        1: ram_write(32'($urandom_range(0, 4 * (1 << RAM_AW) - 1)), $urandom);
        2: io_write(32'hF000_0000 | 32'($urandom_range(0, 3)), $urandom);
        3: io_read(32'hF000_0000 | 32'($urandom_range(0, 3)));
        4: if ($urandom_range(0, 1) == 1)
             io_write(32'hF000_0004, m_cmp - 32'($urandom_range(1, 4)));
           else
             io_write(32'hF000_0004, $urandom);
        5: io_write(32'hF000_0008, $urandom);
        6: io_read(32'hF000_0004 + 32'(4 * $urandom_range(0, 2)));
        7: io_write(32'hF000_000C, 32'($urandom_range(0, 3)));
        8: begin
             if ($urandom_range(0, 1) == 1)
               a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF);
             else
               a = 32'hF000_0010 + 32'(4 * $urandom_range(0, 15));
             if ($urandom_range(0, 1) == 1) io_read(a);
             else io_write(a, $urandom);
           end
        default: idle_cyc();
      endcase
    end

    // Reset asserted while a RAM read waits
    io_write(32'hF000_0000, 32'h0000_FFFF);
    io_write(32'hF000_0008, 32'h0000_0200);
    io_write(32'hF000_0004, 32'h0000_01FF);
    idle_cyc();
    idle_cyc();
    chk("pre_rst_irq", {31'h0, cnt_irq}, 32'h1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040;
    tick();
    #1;
    chk("pre_rst_state_wait", {30'h0, state_dbg}, 32'h1);
    rst = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk("midrst_state", {30'h0, state_dbg}, 32'h0);
    chk("midrst_ready", {31'h0, MIO_ready}, 32'h1);
    chk("midrst_rdata", cpu_rdata, 32'h0);
    chk("midrst_led", {16'h0, led_out}, 32'h0);
    chk("midrst_irq", {31'h0, cnt_irq}, 32'h0);
    chk("midrst_bus_err", {31'h0, bus_err}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    idle_cyc();
    idle_cyc();
    io_read(32'hF000_0004);
    io_read(32'hF000_0008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
